// File: rtl/dogbattle_pkg.sv
// Shared definitions for the dog-battle video path.
// Holds the scene geometry, the pixel-kind codes, the span-table entry
// layout and the scanline prefetch FSM state encoding.
package dogbattle_pkg;

  localparam int N_DOGS   = 4;
  localparam int BOX_W    = 48;
  localparam int BOX_H    = 32;
  localparam int BAR_W    = 6;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  localparam logic [1:0] KIND_BG  = 2'd0;
  localparam logic [1:0] KIND_DOG = 2'd1;
  localparam logic [1:0] KIND_BAR = 2'd2;

  // One dog's contribution to a scanline: which vertical bands it covers
  // on this line, where it starts horizontally, and its color.
  typedef struct packed {
    logic       body_v;
    logic       bar_v;
    logic [9:0] x_lo;
    logic [2:0] color;
  } span_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

endpackage

// File: rtl/dog_span_eval.sv
// Combinational evaluation of one dog against one scanline.
// Ports:
//   y      - scanline being built (0..511)
//   py     - dog top-left y
//   x      - dog top-left x, passed through as the span start
//   color  - dog color index, passed through
//   hits   - dog hit count 0..255, scaled to a bar height of 0..BOX_H
//   span   - resulting table entry {body_v, bar_v, x_lo, color}
module dog_span_eval
  import dogbattle_pkg::*;
(
  input  logic [8:0] y,
  input  logic [8:0] py,
  input  logic [9:0] x,
  input  logic [2:0] color,
  input  logic [7:0] hits,
  output span_t      span
);

  // Bar height: floor(hits * BOX_H / 255), so 255 hits is a full-height bar.
  function automatic logic [5:0] hits_to_h(input logic [7:0] hv);
    logic [15:0] prod;
    logic [15:0] quo;
    prod = {8'd0, hv} * 16'(BOX_H);
    quo  = prod / 16'd255;
    return quo[5:0];
  endfunction

  // Bars of dogs near the top of the screen start above line 0; pin to 0.
  function automatic logic [9:0] clamp_nonneg(input logic signed [9:0] v);
    return v[9] ? 10'd0 : v;
  endfunction

  logic        [9:0] y_w;
  logic        [9:0] py_w;
  logic        [9:0] body_end;
  logic        [5:0] h;
  logic signed [9:0] bar_lo_s;
  logic        [9:0] bar_lo;
  logic              body_v;
  logic              bar_v;

  assign y_w      = {1'b0, y};
  assign py_w     = {1'b0, py};
  assign body_end = py_w + 10'(BOX_H);
  assign h        = hits_to_h(hits);
  assign bar_lo_s = $signed(py_w) - $signed({4'd0, h});
  assign bar_lo   = clamp_nonneg(bar_lo_s);

  assign body_v = (y_w >= py_w) && (y_w < body_end);
  assign bar_v  = (h != 6'd0) && (y_w >= bar_lo) && (y_w < py_w);

  assign span = {body_v, bar_v, x, color};

endmodule

// File: rtl/dog_scanline_prefetch.sv
// Per-scanline dog span table with a one-pixel registered lookup.
// During horizontal blank the dogs are evaluated one per clk50 cycle into a
// shadow bank, which is then committed to the live bank in a single cycle.
// During active video each pix_ce resolves px against the live bank.
// Ports:
//   clk50, rst_n        - 50 MHz clock, asynchronous active-low reset
//   pix_ce              - pixel enable, every other clk50 cycle
//   hblank_start        - starts a table build for next_y
//   next_y              - scanline to build
//   pos_x/pos_y/color/hits_flat - per-dog state, dog i in slice i
//   px, active          - current pixel position and visibility
//   out_kind, out_color - registered lookup result
//   busy                - table build in progress
//   overrun             - sticky: a build was restarted before finishing
module dog_scanline_prefetch
  import dogbattle_pkg::*;
(
  input  logic                  clk50,
  input  logic                  rst_n,
  input  logic                  pix_ce,
  input  logic                  hblank_start,
  input  logic [8:0]            next_y,
  input  logic [N_DOGS*10-1:0]  pos_x_flat,
  input  logic [N_DOGS*9-1:0]   pos_y_flat,
  input  logic [N_DOGS*3-1:0]   color_flat,
  input  logic [N_DOGS*8-1:0]   hits_flat,
  input  logic [9:0]            px,
  input  logic                  active,
  output logic [1:0]            out_kind,
  output logic [2:0]            out_color,
  output logic                  busy,
  output logic                  overrun
);

  localparam int IDX_W = (N_DOGS > 1) ? $clog2(N_DOGS) : 1;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [8:0]       y_lat;
  span_t            shadow [N_DOGS];
  span_t            live   [N_DOGS];

  logic [9:0] sel_x;
  logic [8:0] sel_y;
  logic [2:0] sel_c;
  logic [7:0] sel_h;
  span_t      eval_span;
  span_t      scan_span;
  logic       line_off;

  // The evaluator is shared across dogs; idx steers which dog it sees.
  assign sel_x = pos_x_flat[10*idx +: 10];
  assign sel_y = pos_y_flat[9*idx  +: 9];
  assign sel_c = color_flat[3*idx  +: 3];
  assign sel_h = hits_flat[8*idx   +: 8];

  dog_span_eval u_eval (
    .y     (y_lat),
    .py    (sel_y),
    .x     (sel_x),
    .color (sel_c),
    .hits  (sel_h),
    .span  (eval_span)
  );

  // Lines below the visible area produce an empty table.
  assign line_off  = ({1'b0, y_lat} >= 10'(SCREEN_H));
  assign scan_span = line_off ? span_t'('0) : eval_span;

  // Build FSM: IDLE -> SCAN (one dog per cycle) -> COMMIT -> IDLE
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      idx     <= '0;
      y_lat   <= '0;
      busy    <= 1'b0;
      overrun <= 1'b0;
      for (int i = 0; i < N_DOGS; i++) begin
        shadow[i] <= '0;
        live[i]   <= '0;
      end
    end else if (hblank_start) begin
      // A restart abandons any partial shadow bank without committing it.
      y_lat <= next_y;
      idx   <= '0;
      state <= ST_SCAN;
      busy  <= 1'b1;
      if (state != ST_IDLE) overrun <= 1'b1;
    end else begin
      case (state)
        ST_SCAN: begin
          shadow[idx] <= scan_span;
          if (idx == IDX_W'(N_DOGS - 1)) state <= ST_COMMIT;
          else                            idx   <= idx + 1'b1;
        end
        ST_COMMIT: begin
          for (int i = 0; i < N_DOGS; i++) live[i] <= shadow[i];
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Lookup: later dogs overwrite earlier ones, so the highest index wins.
  logic       bar_hit;
  logic       body_hit;
  logic [2:0] body_color;

  always_comb begin
    bar_hit    = 1'b0;
    body_hit   = 1'b0;
    body_color = 3'd0;
    for (int i = 0; i < N_DOGS; i++) begin
      if (live[i].bar_v && ({1'b0, px} >= {1'b0, live[i].x_lo}) &&
          ({1'b0, px} < ({1'b0, live[i].x_lo} + 11'(BAR_W))))
        bar_hit = 1'b1;
      if (live[i].body_v && ({1'b0, px} >= {1'b0, live[i].x_lo}) &&
          ({1'b0, px} < ({1'b0, live[i].x_lo} + 11'(BOX_W)))) begin
        body_hit   = 1'b1;
        body_color = live[i].color;
      end
    end
  end

  // Output register stage, advanced only on pixel enables
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      out_kind  <= KIND_BG;
      out_color <= 3'd0;
    end else if (pix_ce) begin
      if (!active) begin
        out_kind  <= KIND_BG;
        out_color <= 3'd0;
      end else if (bar_hit) begin
        out_kind  <= KIND_BAR;
        out_color <= 3'd0;
      end else if (body_hit) begin
        out_kind  <= KIND_DOG;
        out_color <= body_color;
      end else begin
        out_kind  <= KIND_BG;
        out_color <= 3'd0;
      end
    end
  end

endmodule

// File: doc/dog_scanline_prefetch.md
Name: dog_scanline_prefetch

Overview:
Sits between game_core_v8 and the VGA pixel generator in the 50 MHz domain. During each horizontal blank it scans the four dogs against the next scanline and builds a per-line span table: body x-range, color, and hit-bar x-range. During active video it answers one lookup per pixel from that table. This replaces the per-pixel compares and divides in the pixel generator with one registered lookup.

Parameters:
N_DOGS, 4, number of dogs scanned per line
BOX_W, 48, dog body width in pixels
BOX_H, 32, dog body height; also the full-scale hit-bar height
BAR_W, 6, hit-bar width in pixels
SCREEN_H, 480, visible lines; next_y >= SCREEN_H yields an empty table

Ports:
clk50  in  1  50 MHz system clock
rst_n  in  1  reset, asynchronous, active-low
pix_ce  in  1  pixel clock enable, one clk50 cycle in two
hblank_start  in  1  one-cycle pulse, aligned to pix_ce, at the start of horizontal blank
next_y  in  9  scanline the table is built for; sampled on hblank_start
pos_x_flat  in  N_DOGS*10  dog top-left x, dog i in bits [10i+9:10i]
pos_y_flat  in  N_DOGS*9  dog top-left y
color_flat  in  N_DOGS*3  dog color index
hits_flat  in  N_DOGS*8  dog hit count, 0..255
px  in  10  current pixel x
active  in  1  current pixel is visible
out_kind  out  2  0 = background, 1 = dog body, 2 = hit bar
out_color  out  3  color index of the winning dog (0 for background and bar)
busy  out  1  scan in progress
overrun  out  1  sticky: a hblank_start arrived while busy

Behaviour:
- Reset:
  - State IDLE; both table banks cleared (all entries invalid).
  - out_kind=0, out_color=0, busy=0, overrun=0.
- FSM: IDLE -> SCAN -> COMMIT -> IDLE.
  - IDLE: on hblank_start, latch next_y, set dog index i=0, go to SCAN, set busy=1.
  - SCAN: one dog per clk50 cycle, i = 0..N_DOGS-1. Dog i's inputs are sampled in its own cycle. The result is written to shadow entry i. After i = N_DOGS-1, go to COMMIT.
  - COMMIT: copy the shadow bank to the live bank atomically in one cycle, clear busy, return to IDLE.
  - busy is high for exactly N_DOGS+1 cycles.
- Per-dog evaluation, all unsigned and widened so nothing wraps:
  - body_v = (y >= py) && (y < py + BOX_H). Use a 10-bit sum.
  - h = floor(hits*BOX_H/255). For BOX_H=32 the range is 0..32.
  - bar_lo = max(py - h, 0). Compute as 10-bit signed, then clamp negative to 0.
  - bar_v = (h != 0) && (y >= bar_lo) && (y < py).
  - Stored entry: {body_v, bar_v, x_lo = px_i, color}.
  - Horizontal range is checked at lookup: body covers [x_lo, x_lo+BOX_W); bar covers [x_lo, x_lo+BAR_W). Use 11-bit sums, so no wrap at x near 640.
  - If latched y >= SCREEN_H, force all entries invalid.
- Lookup:
  - On each pix_ce with active=1, evaluate the live bank against px and register the result. Latency is one pixel (visible on the next pix_ce).
  - Priority: any bar hit wins over any body hit. Within each class, the highest dog index wins.
  - Bar result: kind=2, color=0. Body result: kind=1, color = that dog's color. Neither: kind=0, color=0.
  - On pix_ce with active=0: outputs go to 0. Between pix_ce pulses, outputs hold.
- Simultaneous events:
  - A lookup in the same cycle as COMMIT uses the old live bank.
  - hblank_start while busy: set overrun (sticky until reset), re-latch next_y, restart SCAN at i=0. The shadow bank is overwritten and no commit happens for the aborted scan.
- Reset asserted mid-scan: immediate return to reset state; the next line shows background until a full scan completes.

Decomposition:
- Shared package dogbattle_pkg holds:
  - N_DOGS, BOX_W, BOX_H, BAR_W, SCREEN_W, SCREEN_H.
  - KIND_BG=0, KIND_DOG=1, KIND_BAR=2.
  - The span-entry struct/typedef {body_v, bar_v, x_lo[9:0], color[2:0]}.
- One natural sub-module: dog_span_eval, a combinational per-dog evaluation (y vs py, hits-to-height, clamp). It is shared by the SCAN datapath and stepped by index.

Test Plan:
1. Reset: assert rst_n=0 mid-run -> out_kind=0, out_color=0, busy=0, overrun=0; next line is all background.
2. Dog0 at (100,50), color 5, hits 0; hblank_start, next_y=60 -> busy high for 5 cycles. px=100 -> kind 1, color 5. px=147 -> kind 1. px=148 -> kind 0. px=99 -> kind 0.
3. Dog0 at (100,50), hits 255 (h=32):
   - next_y=18, px=100..105 -> kind 2; px=106 -> kind 0.
   - next_y=17 -> background.
   - next_y=50 -> kind 1 across 100..147.
4. Dog0 and dog1 both at (200,100), colors 1 and 6, next_y=110 -> kind 1, color 6. Add hits1=128 with next_y=99 -> kind 2 at px=200.
5. Clamp case: dog2 at (300,10), hits 255, next_y=0 -> kind 2 at px=300. With next_y=480 -> background everywhere, even with a dog at y=470.
6. Overrun: second hblank_start 2 cycles after the first with next_y=70 -> overrun=1, busy high 5 more cycles, table reflects y=70 only.
